// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) with ready/ack handshake,
// sticky overrun and one-cycle frame/parity error pulses.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ack,
   output logic                 overrun,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {st_idle, st_start, st_data, st_parity, st_stop, st_break} state_t;
`else
   typedef enum logic [2:0] {st_idle, st_start, st_data, st_stop, st_break} state_t;
`endif

   state_t               state;
   logic                 sync1;
   logic                 rxs;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        nbit;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr;
   logic                 tick;
   logic                 deliver;

   // Start bit waits half a bit so every later sample lands mid-bit.
   always_comb begin
      tick    = (state == st_start) ? (cnt == HALF) : (cnt == FULL);
      deliver = (state == st_stop) && tick && rxs && !perr;
   end

`ifndef UART_RX_PARITY_EN
   assign perr       = 1'b0;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1     <= 1'b1;
         rxs       <= 1'b1;
         state     <= st_idle;
         cnt       <= '0;
         nbit      <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr       <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         sync1     <= rx_in;
         rxs       <= sync1;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         cnt <= cnt + CW'(1);
         unique case (state)
            st_idle: begin
               cnt <= '0;
               if (!rxs) begin
                  state <= st_start;
                  nbit  <= '0;
               end
            end
            st_start: begin
               if (tick) begin
                  cnt   <= '0;
                  state <= rxs ? st_idle : st_data;
               end
            end
            st_data: begin
               if (tick) begin
                  cnt   <= '0;
                  shreg <= {rxs, shreg[DATA_BITS-1:1]};
                  nbit  <= nbit + BW'(1);
                  if (nbit == LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= st_parity;
`else
                     state <= st_stop;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            st_parity: begin
               if (tick) begin
                  cnt   <= '0;
                  perr  <= rxs ^ (^shreg);
                  state <= st_stop;
               end
            end
`endif
            st_stop: begin
               if (tick) begin
                  cnt <= '0;
                  if (!rxs) begin
                     frame_err <= 1'b1;
                     state     <= st_break;
                  end else begin
`ifdef UART_RX_PARITY_EN
                     parity_err <= perr;
`endif
                     state <= st_idle;
                  end
               end
            end
            st_break: begin
               cnt <= '0;
               if (rxs) state <= st_idle;
            end
            default: state <= st_idle;
         endcase

         // Ack is applied before a same-cycle delivery so the new byte still loads.
         if (rx_ack && rx_valid) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
         if (deliver) begin
            if (!rx_valid || rx_ack) begin
               rx_data  <= shreg;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame outcomes are predicted when sent and checked by a monitor.
module tb_uart_rx;

   localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam bit PEN = 1'b1;
   localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
   localparam bit PEN = 1'b0;
   localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_in = 1'b1;
   logic       rx_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, overrun, frame_err, parity_err;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ack     (rx_ack),
      .overrun    (overrun),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   typedef struct {
      int         kind;   // 0 delivery, 1 frame error, 2 parity error
      logic [7:0] data;
      longint     at;
   } ev_t;

   ev_t        q[$];
   int         checks = 0;
   int         failures = 0;
   longint     cyc = 0;
   bit         mvalid = 1'b0;
   bit         mover = 1'b0;
   logic [7:0] mdata = 8'h00;
   logic       pv = 1'b0;
   logic       pa = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input logic [7:0] d);
      ev_t e;
      if (q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_event: got kind %0d data 0x%0h expected none (cycle %0d)",
                  kind, d, cyc);
      end else begin
         e = q.pop_front();
         chk("event_kind", 64'(kind), 64'(e.kind));
         chk("event_cycle", 64'(cyc), 64'(e.at));
         if (kind == 0) chk("rx_data", 64'(d), 64'(e.data));
      end
   endtask

   // A byte is freshly presented when valid now and the previous cycle did not hold an unacked byte.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && !(pv && !pa)) expect_ev(0, rx_data);
         if (frame_err) expect_ev(1, 8'h00);
         if (parity_err) expect_ev(2, 8'h00);
      end
      pv = rx_valid;
      pa = rx_ack;
   end

   task automatic model_frame(input logic [7:0] d, input bit stopb, input bit parb,
                              input longint t0);
      ev_t e;
      e.data = d;
      e.at   = t0 + LAT;
      e.kind = 0;
      if (!stopb) begin
         e.kind = 1;
         q.push_back(e);
      end else if (PEN && (parb != ^d)) begin
         e.kind = 2;
         q.push_back(e);
      end else if (!mvalid) begin
         mvalid = 1'b1;
         mdata  = d;
         q.push_back(e);
      end else begin
         mover = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stopb, input bit parb, input int hold);
      @(posedge clk);
      #1 rx_in = 1'b0;
      model_frame(d, stopb, parb, cyc);
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx_in = d[i];
         repeat (CPB) @(posedge clk);
      end
      if (PEN) begin
         #1 rx_in = parb;
         repeat (CPB) @(posedge clk);
      end
      #1 rx_in = stopb;
      repeat (CPB) @(posedge clk);
      repeat (hold) @(posedge clk);
      #1 rx_in = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic check_state();
      @(negedge clk);
      chk("rx_valid", 64'(rx_valid), 64'(mvalid));
      chk("overrun", 64'(overrun), 64'(mover));
      if (mvalid) chk("rx_data_held", 64'(rx_data), 64'(mdata));
   endtask

   task automatic ack_pulse();
      @(posedge clk);
      #1 rx_ack = 1'b1;
      @(posedge clk);
      #1 rx_ack = 1'b0;
      if (mvalid) begin
         mvalid = 1'b0;
         mover  = 1'b0;
      end
      check_state();
   endtask

   initial begin
      logic [7:0] d;
      bit         bad, pbad;

      #2 rst = 1'b1;
      idle(3);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_rx_data", 64'(rx_data), 64'h0);
      chk("reset_rx_valid", 64'(rx_valid), 64'h0);
      chk("reset_overrun", 64'(overrun), 64'h0);
      chk("reset_frame_err", 64'(frame_err), 64'h0);
      chk("reset_parity_err", 64'(parity_err), 64'h0);

      // Basic byte, held until acknowledged.
      send_frame(8'hA5, 1'b1, ^8'hA5, 0);
      idle(30);
      check_state();
      ack_pulse();

      // Short glitch must be rejected, then a real byte.
      @(posedge clk);
      #1 rx_in = 1'b0;
      idle(3);
      #1 rx_in = 1'b1;
      idle(20);
      send_frame(8'h3C, 1'b1, ^8'h3C, 0);
      check_state();
      ack_pulse();

      // Low stop bit followed by a held-low line: one frame error only.
      send_frame(8'h55, 1'b0, ^8'h55, 40);
      idle(6);
      check_state();
      send_frame(8'h81, 1'b1, ^8'h81, 0);
      check_state();
      ack_pulse();

      // Overrun: second byte dropped while first is unacked.
      send_frame(8'h11, 1'b1, ^8'h11, 0);
      send_frame(8'h22, 1'b1, ^8'h22, 0);
      check_state();
      ack_pulse();
      send_frame(8'h33, 1'b1, ^8'h33, 0);
      check_state();
      send_frame(8'h44, 1'b1, ^8'h44, 0);
      check_state();

      // Ack on the delivery edge: new byte loads, overrun cleared and not re-set.
      if (mvalid) begin
         mvalid = 1'b0;
         mover  = 1'b0;
      end
      fork
         send_frame(8'h5A, 1'b1, ^8'h5A, 0);
         begin
            @(posedge clk);
            repeat (LAT - 1) @(posedge clk);
            #1 rx_ack = 1'b1;
            @(posedge clk);
            #1 rx_ack = 1'b0;
         end
      join
      check_state();

      // Reset during data bit 4 of 0xFF aborts the frame.
      @(posedge clk);
      #1 rx_in = 1'b0;
      idle(CPB);
      for (int i = 0; i < 4; i++) begin
         #1 rx_in = 1'b1;
         idle(CPB);
      end
      #1 rx_in = 1'b1;
      idle(CPB / 2);
      #1 rst = 1'b1;
      mvalid = 1'b0;
      mover  = 1'b0;
      mdata  = 8'h00;
      idle(2);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rx_data", 64'(rx_data), 64'h0);
      chk("rst_rx_valid", 64'(rx_valid), 64'h0);
      chk("rst_overrun", 64'(overrun), 64'h0);
      chk("rst_frame_err", 64'(frame_err), 64'h0);
      chk("rst_parity_err", 64'(parity_err), 64'h0);
      idle(100);
      send_frame(8'h0F, 1'b1, ^8'h0F, 0);
      check_state();
      ack_pulse();

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, 0);
      check_state();
      send_frame(8'h07, 1'b1, 1'b1, 0);
      check_state();
      ack_pulse();
`endif

      // Randomised frames with random errors, gaps and acks.
      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         bad  = ($urandom_range(0, 7) == 0);
         pbad = PEN && ($urandom_range(0, 3) == 0);
         send_frame(d, !bad, (^d) ^ pbad, bad ? 30 : 0);
         if (bad) idle(6);
         check_state();
         if ($urandom_range(0, 1) == 1) ack_pulse();
         idle($urandom_range(0, 5));
      end

      idle(LAT + 20);
      chk("queue_drained", 64'(q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
